// File: rtl/insmem_prefetch_unit.sv
// insmem_prefetch_unit
// Pipelined instruction-fetch front end: keeps up to MAXOUT in-order memory
// requests in flight and queues returned words, each tagged with its PC, in a
// DEPTH-entry FIFO. A redirect flushes the FIFO and drops in-flight responses.
// Optional feature macro: PFU_MISALIGN_TRAP_EN adds PFU_Misalign_Out and halts
// fetching after a redirect to a non-word-aligned address.
module insmem_prefetch_unit #(
  parameter int                   DATAWIDTH  = 32,
  parameter int                   DEPTH      = 4,
  parameter int                   MAXOUT     = 2,
  parameter logic [DATAWIDTH-1:0] RESET_PC   = '0,
  parameter int                   INSMEMSTEP = 4
) (
  input  logic                 PFU_Clk_In,
  input  logic                 PFU_Reset_In,
  output logic                 PFU_Mem_Req_Out,
  output logic [DATAWIDTH-1:0] PFU_Mem_Addr_OutBUS,
  input  logic                 PFU_Mem_Gnt_In,
  input  logic                 PFU_Mem_Valid_In,
  input  logic [DATAWIDTH-1:0] PFU_Mem_Readdata_InBUS,
  output logic                 PFU_Ins_Valid_Out,
  output logic [DATAWIDTH-1:0] PFU_Ins_Data_OutBUS,
  output logic [DATAWIDTH-1:0] PFU_Ins_Pc_OutBUS,
  input  logic                 PFU_Ins_Ready_In,
  input  logic                 PFU_Redirect_In,
  input  logic [DATAWIDTH-1:0] PFU_Redirect_Addr_InBUS
`ifdef PFU_MISALIGN_TRAP_EN
  ,
  output logic                 PFU_Misalign_Out
`endif
);

  localparam int OUTW = $clog2(MAXOUT + 1);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = $clog2(DEPTH);
  localparam int SUMW = CNTW + 1;

  logic [DATAWIDTH-1:0] fetchPc;
  logic [DATAWIDTH-1:0] respPc;
  logic [DATAWIDTH-1:0] pcStore   [DEPTH];
  logic [DATAWIDTH-1:0] dataStore [DEPTH];
  logic [OUTW-1:0]      outstanding;
  logic [OUTW-1:0]      discard;
  logic [CNTW-1:0]      count;
  logic [PTRW-1:0]      rdPtr;
  logic [PTRW-1:0]      wrPtr;
  logic [SUMW-1:0]      occupancy;
  logic [DATAWIDTH-1:0] redirectPc;
  logic                 halted;
  logic                 reqFire;
  logic                 respValid;
  logic                 pushEn;
  logic                 popEn;

`ifdef PFU_MISALIGN_TRAP_EN
  logic misalign;

  // A misaligned redirect is loaded as-is; fetching stays halted until an aligned one arrives
  always_comb begin
    redirectPc = PFU_Redirect_Addr_InBUS;
    halted     = misalign;
  end

  // Sticky trap flag, updated only by redirects
  always_ff @(posedge PFU_Clk_In) begin
    if (PFU_Reset_In) begin
      misalign <= 1'b0;
    end else if (PFU_Redirect_In) begin
      misalign <= |PFU_Redirect_Addr_InBUS[1:0];
    end
  end

  assign PFU_Misalign_Out = misalign;
`else
  // Without the trap the redirect target is silently word-aligned
  always_comb begin
    redirectPc = PFU_Redirect_Addr_InBUS & ~DATAWIDTH'(3);
    halted     = 1'b0;
  end
`endif

  // Request gating: requests in flight plus buffered words must never exceed the FIFO,
  // so every response is guaranteed a free slot
  always_comb begin
    occupancy       = SUMW'(outstanding) + SUMW'(count);
    PFU_Mem_Req_Out = !PFU_Reset_In && !PFU_Redirect_In && !halted &&
                      (outstanding < OUTW'(MAXOUT)) && (occupancy < SUMW'(DEPTH));
    reqFire         = PFU_Mem_Req_Out && PFU_Mem_Gnt_In;
    respValid       = PFU_Mem_Valid_In && (outstanding != '0);
    pushEn          = respValid && (discard == '0) && !PFU_Redirect_In;
    popEn           = (count != '0) && PFU_Ins_Ready_In && !PFU_Redirect_In;
  end

  // Fetch/response address tracking, outstanding and discard counters, FIFO pointers
  always_ff @(posedge PFU_Clk_In) begin
    if (PFU_Reset_In) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
    end else if (PFU_Redirect_In) begin
      fetchPc     <= redirectPc;
      respPc      <= redirectPc;
      outstanding <= outstanding - OUTW'(respValid);
      discard     <= outstanding - OUTW'(respValid);
      count       <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
    end else begin
      if (reqFire) begin
        fetchPc <= fetchPc + DATAWIDTH'(INSMEMSTEP);
      end
      outstanding <= outstanding + OUTW'(reqFire) - OUTW'(respValid);
      if (respValid && (discard != '0)) begin
        discard <= discard - OUTW'(1);
      end
      if (pushEn) begin
        respPc <= respPc + DATAWIDTH'(INSMEMSTEP);
        wrPtr  <= wrPtr + PTRW'(1);
      end
      if (popEn) begin
        rdPtr <= rdPtr + PTRW'(1);
      end
      count <= count + CNTW'(pushEn) - CNTW'(popEn);
    end
  end

  // FIFO storage: each accepted word is written together with the PC it was fetched from
  always_ff @(posedge PFU_Clk_In) begin
    if (PFU_Reset_In) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcStore[i]   <= '0;
        dataStore[i] <= '0;
      end
    end else if (pushEn) begin
      pcStore[wrPtr]   <= respPc;
      dataStore[wrPtr] <= PFU_Mem_Readdata_InBUS;
    end
  end

  assign PFU_Mem_Addr_OutBUS = fetchPc;
  assign PFU_Ins_Valid_Out   = (count != '0);
  assign PFU_Ins_Data_OutBUS = dataStore[rdPtr];
  assign PFU_Ins_Pc_OutBUS   = pcStore[rdPtr];

endmodule

// File: tb/tb_insmem_prefetch_unit.sv
// tb_insmem_prefetch_unit
// Drives the prefetch unit with directed and random traffic from an in-order
// memory model and compares every cycle against a queue-based reference of
// which words the consumer should see. Honours PFU_MISALIGN_TRAP_EN.
module tb_insmem_prefetch_unit;

  localparam int          DEPTH      = 4;
  localparam int          MAXOUT     = 2;
  localparam logic [31:0] RESET_PC   = 32'hFFFF_FFF8;
  localparam int          INSMEMSTEP = 4;
  localparam logic [31:0] KEY        = 32'hA5A5_A5A5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } insEntry_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt = 1'b0;
  logic        memValid = 1'b0;
  logic [31:0] memData = '0;
  logic        insValid;
  logic [31:0] insData;
  logic [31:0] insPc;
  logic        insReady = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectAddr = '0;
`ifdef PFU_MISALIGN_TRAP_EN
  logic        misalignOut;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  logic [31:0] pendQ[$];
  int          staleCount = 0;
  insEntry_t   expQ[$];
  logic [31:0] modelPc = RESET_PC;
  logic        modelHalted = 1'b0;
  logic        prevRst = 1'b0;

  insmem_prefetch_unit #(
    .DATAWIDTH (32),
    .DEPTH     (DEPTH),
    .MAXOUT    (MAXOUT),
    .RESET_PC  (RESET_PC),
    .INSMEMSTEP(INSMEMSTEP)
  ) dut (
    .PFU_Clk_In             (clock),
    .PFU_Reset_In           (reset),
    .PFU_Mem_Req_Out        (memReq),
    .PFU_Mem_Addr_OutBUS    (memAddr),
    .PFU_Mem_Gnt_In         (memGnt),
    .PFU_Mem_Valid_In       (memValid),
    .PFU_Mem_Readdata_InBUS (memData),
    .PFU_Ins_Valid_Out      (insValid),
    .PFU_Ins_Data_OutBUS    (insData),
    .PFU_Ins_Pc_OutBUS      (insPc),
    .PFU_Ins_Ready_In       (insReady),
    .PFU_Redirect_In        (redirect),
    .PFU_Redirect_Addr_InBUS(redirectAddr)
`ifdef PFU_MISALIGN_TRAP_EN
    ,
    .PFU_Misalign_Out       (misalignOut)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, advance the model, wait for the rising edge
  task automatic applyStimulus(input logic rst, input logic gnt, input logic ready,
                               input logic redir, input logic [31:0] redirAddr, input logic respond);
    logic        expReq;
    logic [31:0] addr;
    insEntry_t   ent;
    @(negedge clock);
    reset        = rst;
    memGnt       = gnt;
    insReady     = ready;
    redirect     = redir;
    redirectAddr = redirAddr;
    memValid     = respond;
    memData      = (pendQ.size() > 0) ? (pendQ[0] ^ KEY) : $urandom;
    #1;
    expReq = !rst && !redir && !modelHalted && (pendQ.size() < MAXOUT) &&
             ((pendQ.size() + expQ.size()) < DEPTH);
    if (rst) begin
      checkOutput("rstReq", {31'b0, memReq}, 32'h0);
      if (prevRst) begin
        checkOutput("rstValid", {31'b0, insValid}, 32'h0);
        checkOutput("rstData", insData, 32'h0);
        checkOutput("rstPc", insPc, 32'h0);
`ifdef PFU_MISALIGN_TRAP_EN
        checkOutput("rstMisalign", {31'b0, misalignOut}, 32'h0);
`endif
      end
    end else begin
      checkOutput("memReq", {31'b0, memReq}, {31'b0, expReq});
      if (expReq) checkOutput("memAddr", memAddr, modelPc);
      checkOutput("insValid", {31'b0, insValid}, {31'b0, (expQ.size() != 0)});
      if (expQ.size() != 0) begin
        checkOutput("insPc", insPc, expQ[0].pc);
        checkOutput("insData", insData, expQ[0].data);
      end
`ifdef PFU_MISALIGN_TRAP_EN
      checkOutput("misalign", {31'b0, misalignOut}, {31'b0, modelHalted});
`endif
    end

    if (rst) begin
      pendQ.delete();
      expQ.delete();
      staleCount  = 0;
      modelPc     = RESET_PC;
      modelHalted = 1'b0;
    end else if (redir) begin
      if (respond && pendQ.size() > 0) addr = pendQ.pop_front();
      staleCount = pendQ.size();
      expQ.delete();
`ifdef PFU_MISALIGN_TRAP_EN
      modelPc     = redirAddr;
      modelHalted = (redirAddr[1:0] != 2'b00);
`else
      modelPc     = {redirAddr[31:2], 2'b00};
`endif
    end else begin
      if (ready && expQ.size() > 0) ent = expQ.pop_front();
      if (respond && pendQ.size() > 0) begin
        addr = pendQ.pop_front();
        if (staleCount > 0) begin
          staleCount--;
        end else begin
          ent.pc   = addr;
          ent.data = addr ^ KEY;
          expQ.push_back(ent);
        end
      end
      if (expReq && gnt) begin
        pendQ.push_back(modelPc);
        modelPc = modelPc + INSMEMSTEP;
      end
    end
    prevRst = rst;
    @(posedge clock);
  endtask

  initial begin
    logic rstR, gntR, readyR, redirR, respR;
    logic [31:0] addrR;

    // Reset, then stray responses with nothing outstanding
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0, 0, 1);

    // Streaming across the address wrap from the reset PC
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 0, 0, 1);

    // Streaming from address 0
    applyStimulus(0, 1, 1, 1, 32'h0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 0, 0, 1);

    // Fill the FIFO with the consumer stalled, release a single pop, then drain
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0, 0, 1);

    // Two requests in flight, then redirect to 0x100; stale responses arrive afterwards
    applyStimulus(0, 1, 1, 1, 32'h8, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 32'h100, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 0, 0, 1);

    // Redirect coinciding with a response and a pop
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 1, 32'h40, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 0, 0, 1);

    // Back-to-back redirects, last one wins
    applyStimulus(0, 1, 1, 1, 32'h300, 1);
    applyStimulus(0, 1, 1, 1, 32'h500, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0, 0, 1);

    // Misaligned redirect, then an aligned one
    applyStimulus(0, 1, 1, 1, 32'h102, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0, 0, 1);
    applyStimulus(0, 1, 1, 1, 32'h200, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 0, 0, 1);

    // Reset in the middle of traffic
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 1);
    applyStimulus(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rstR   = ($urandom_range(0, 199) == 0);
      redirR = ($urandom_range(0, 29) == 0);
      gntR   = ($urandom_range(0, 3) != 0);
      readyR = ($urandom_range(0, 1) == 1);
      respR  = ($urandom_range(0, 1) == 1);
      addrR  = $urandom;
      if ($urandom_range(0, 3) != 0) addrR[1:0] = 2'b00;
      applyStimulus(rstR, gntR, readyR, redirR, addrR, respR);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
